// File: rtl/compressor_tree_pkg.sv
// rtl/compressor_tree_pkg.sv - shared types and sizing helpers for the carry-save reduction tree
package compressor_tree_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_sb_t;

  function automatic int tree_layers(input int n);
    return $clog2(n) - 1;
  endfunction

  function automatic int layer_width(input int n, input int k);
    return n >> k;
  endfunction

  // Stage k's vectors start at this index in the flattened stage register file.
  function automatic int stage_offset(input int n, input int k);
    return 2 * n - 2 * (n >> k);
  endfunction

endpackage

// File: rtl/compressor_tree_if.sv
// rtl/compressor_tree_if.sv - beat/result handshake bundle between producer, tree and adder
interface compressor_tree_if #(
  parameter int N_IN     = 8,
  parameter int IN_SIZE  = 14,
  parameter int OUT_SIZE = 20
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [IN_SIZE-1:0]  in_data_i [N_IN];
  logic                in_first_i;
  logic                in_last_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [OUT_SIZE-1:0] sum_o;
  logic [OUT_SIZE-1:0] carry_o;

  modport slave (
    input  in_valid_i, in_data_i, in_first_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, carry_o
  );

  modport master (
    output in_valid_i, in_data_i, in_first_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, carry_o
  );
endinterface

// File: rtl/compressor_4_2_cell.sv
// rtl/compressor_4_2_cell.sv - single-bit 4:2 compressor built from two chained full adders
module compressor_4_2_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);
  logic s1;

  // cout does not depend on cin, so the lateral chain never ripples.
  assign s1    = a ^ b ^ c;
  assign cout  = (a & b) | (a & c) | (b & c);
  assign sum   = s1 ^ d ^ cin;
  assign carry = (s1 & d) | (s1 & cin) | (d & cin);
endmodule

// File: rtl/compressor_tree_layer.sv
// rtl/compressor_tree_layer.sv - combinational layer reducing N_VEC vectors to N_VEC/2 via 4:2 cells
module compressor_tree_layer #(
  parameter int N_VEC = 4,
  parameter int WIDTH = 20
) (
  input  logic [N_VEC-1:0][WIDTH-1:0]   in_vec,
  output logic [N_VEC/2-1:0][WIDTH-1:0] out_vec
);
  for (genvar g = 0; g < N_VEC / 4; g++) begin : g_grp
    logic [WIDTH-1:0] s;
    logic [WIDTH-2:0] c;
    logic [WIDTH-2:0] co;
    logic [WIDTH-1:0] cin_v;

    assign cin_v = {co, 1'b0};

    for (genvar b = 0; b < WIDTH - 1; b++) begin : g_bit
      compressor_4_2_cell u_cell (
        .a     (in_vec[4*g][b]),
        .b     (in_vec[4*g+1][b]),
        .c     (in_vec[4*g+2][b]),
        .d     (in_vec[4*g+3][b]),
        .cin   (cin_v[b]),
        .sum   (s[b]),
        .carry (c[b]),
        .cout  (co[b])
      );
    end

    // At the MSB both weight-2 outputs fall off the end, only the sum bit survives.
    assign s[WIDTH-1] = ^{in_vec[4*g][WIDTH-1], in_vec[4*g+1][WIDTH-1],
                          in_vec[4*g+2][WIDTH-1], in_vec[4*g+3][WIDTH-1], cin_v[WIDTH-1]};

    assign out_vec[2*g]   = s;
    assign out_vec[2*g+1] = {c, 1'b0};
  end
endmodule

// File: rtl/compressor_tree.sv
// rtl/compressor_tree.sv - pipelined N-operand 4:2 reduction tree with carry-save packet accumulator
module compressor_tree
  import compressor_tree_pkg::*;
#(
  parameter int N_IN     = 8,
  parameter int IN_SIZE  = 14,
  parameter int OUT_SIZE = 20,
  parameter int ACC_EN   = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  compressor_tree_if.slave bus
);
  localparam int L     = tree_layers(N_IN);
  localparam int TOTAL = stage_offset(N_IN, L + 1);

  logic                          en;
  logic [TOTAL-1:0][OUT_SIZE-1:0] vec_q;
  logic [TOTAL-1:0][OUT_SIZE-1:0] vec_d;
  stage_sb_t [L:0]               sb_q;
  logic [OUT_SIZE-1:0]           acc_sum;
  logic [OUT_SIZE-1:0]           acc_carry;
  logic                          out_valid;
  logic [3:0][OUT_SIZE-1:0]      acc_in;
  logic [1:0][OUT_SIZE-1:0]      acc_next;
  logic                          acc_first;
  logic                          acc_last;
  logic                          acc_write;

  assign en              = !(out_valid && !bus.out_ready_i);
  assign bus.in_ready_o  = en;
  assign bus.out_valid_o = out_valid;
  assign bus.sum_o       = acc_sum;
  assign bus.carry_o     = acc_carry;

  for (genvar i = 0; i < N_IN; i++) begin : g_ext
    logic signed [IN_SIZE-1:0] op;
    assign op       = bus.in_data_i[i];
    assign vec_d[i] = OUT_SIZE'(op);
  end

  for (genvar k = 1; k <= L; k++) begin : g_layer
    localparam int NI = layer_width(N_IN, k - 1);
    localparam int NO = layer_width(N_IN, k);
    localparam int OI = stage_offset(N_IN, k - 1);
    localparam int OO = stage_offset(N_IN, k);

    compressor_tree_layer #(.N_VEC(NI), .WIDTH(OUT_SIZE)) u_layer (
      .in_vec  (vec_q[OI +: NI]),
      .out_vec (vec_d[OO +: NO])
    );
  end

  assign acc_first = (ACC_EN == 0) || sb_q[L].first;
  assign acc_last  = (ACC_EN == 0) || sb_q[L].last;
  assign acc_write = en && sb_q[L].valid;

  always_comb begin
    acc_in[0] = vec_q[TOTAL-2];
    acc_in[1] = vec_q[TOTAL-1];
    acc_in[2] = acc_first ? '0 : acc_sum;
    acc_in[3] = acc_first ? '0 : acc_carry;
  end

  compressor_tree_layer #(.N_VEC(4), .WIDTH(OUT_SIZE)) u_acc (
    .in_vec  (acc_in),
    .out_vec (acc_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vec_q     <= '0;
      sb_q      <= '0;
      acc_sum   <= '0;
      acc_carry <= '0;
      out_valid <= 1'b0;
    end else begin
      if (en) begin
        vec_q   <= vec_d;
        sb_q[0] <= '{valid: bus.in_valid_i, first: bus.in_first_i, last: bus.in_last_i};
        for (int k = 1; k <= L; k++) begin
          sb_q[k] <= sb_q[k-1];
        end
      end
      if (acc_write) begin
        acc_sum   <= acc_next[0];
        acc_carry <= acc_next[1];
      end
      // A new last beat wins over the handshake that would clear the flag.
      if (acc_write && acc_last) begin
        out_valid <= 1'b1;
      end else if (out_valid && bus.out_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
